// File: rtl/llc_input_scheduler_pkg.sv
// Shared types for the LLC input scheduler: channel ids, scheduler states and
// the descriptor presented to the input decoder.
package llc_input_scheduler_pkg;

    // Widest set index the descriptor can carry; the top slices down to SET_BITS.
    localparam int LLC_SET_W_MAX = 16;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_RSP = 2'd1,
        SRC_REQ = 2'd2,
        SRC_DMA = 2'd3
    } llc_src_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SWEEP  = 2'd1,
        RECALL = 2'd2
    } llc_sched_state_t;

    typedef struct packed {
        llc_src_t                 src;
        logic                     sweep;
        logic                     flush;
        logic [LLC_SET_W_MAX-1:0] set;
    } llc_sched_desc_t;

endpackage

// File: rtl/llc_input_scheduler_age.sv
// Starvation age counter: counts blocked cycles of one channel, saturating at
// STARVE_LIMIT, and flags the channel as promoted once the limit is reached.
module llc_age_counter #(
    parameter int AGE_W        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [AGE_W-1:0] age,
    output logic             promoted
);

    logic [AGE_W-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (clr) begin
            age_d = '0;
        end else if (inc && (age_q != AGE_W'(STARVE_LIMIT))) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age      = age_q;
    assign promoted = (age_q == AGE_W'(STARVE_LIMIT));

endmodule

// File: rtl/llc_input_scheduler.sv
// Four-channel LLC input arbiter with reset/flush set sweep, recall window and
// REQ/DMA anti-starvation aging; output is a registered valid/ready descriptor.
module llc_input_scheduler
    import llc_input_scheduler_pkg::*;
#(
    parameter int SET_BITS     = 8,
    parameter int STARVE_LIMIT = 15,
    parameter int AGE_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_tb_valid,
    input  logic                rst_tb_flush,
    input  logic                rsp_valid,
    input  logic                req_valid,
    input  logic                dma_valid,
    input  logic                req_stall,
    input  logic                dma_busy,
    input  logic                recall_start,
    input  logic                recall_done,
    output logic                rst_tb_pop,
    output logic                rsp_pop,
    output logic                req_pop,
    output logic                dma_pop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_src,
    output logic                out_sweep,
    output logic                out_flush,
    output logic [SET_BITS-1:0] out_set,
    output logic                sweep_done,
    output logic                in_recall,
    output logic                idle
);

    llc_sched_state_t    state_q, state_d;
    llc_sched_desc_t     desc_q, desc_d;
    logic                out_valid_q, out_valid_d;
    logic [SET_BITS-1:0] cnt_q, cnt_d;
    logic                flush_q, flush_d;
    logic                pending_q, pending_d;
    logic                sweep_done_q, sweep_done_d;

    logic load, last_accept, recall_open;
    logic g_rst, g_rsp, g_req, g_dma;

    // Index 0 = REQ, index 1 = DMA.
    logic [1:0]            age_valid, age_grant, age_inc, age_clr, age_prom;
    logic [1:0][AGE_W-1:0] unused_age;

    assign load        = !out_valid_q || out_ready;
    assign last_accept = out_valid_q && out_ready && desc_q.sweep &&
                         (desc_q.set[SET_BITS-1:0] == {SET_BITS{1'b1}});
    // A simultaneous recall_done cancels the recall_start.
    assign recall_open = recall_start && !recall_done;

    assign age_valid = {dma_valid, req_valid};
    assign age_grant = {g_dma, g_req};

    for (genvar gi = 0; gi < 2; gi++) begin : g_age
        assign age_inc[gi] = (state_q == RUN) && age_valid[gi] && !req_stall &&
                             load && !age_grant[gi];
        assign age_clr[gi] = !age_valid[gi] || age_grant[gi];

        llc_age_counter #(
            .AGE_W        (AGE_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_age (
            .clk      (clk),
            .rst      (rst),
            .inc      (age_inc[gi]),
            .clr      (age_clr[gi]),
            .age      (unused_age[gi]),
            .promoted (age_prom[gi])
        );
    end

    if (SET_BITS < LLC_SET_W_MAX) begin : g_set_pad
        logic unused_set_hi;
        assign unused_set_hi = ^desc_q.set[LLC_SET_W_MAX-1:SET_BITS];
    end

    always_comb begin
        g_rst        = 1'b0;
        g_rsp        = 1'b0;
        g_req        = 1'b0;
        g_dma        = 1'b0;
        state_d      = state_q;
        desc_d       = desc_q;
        out_valid_d  = out_valid_q;
        cnt_d        = cnt_q;
        flush_d      = flush_q;
        pending_d    = pending_q;
        sweep_done_d = 1'b0;

        // Channel selection; only a load cycle may grant.
        if (load) begin
            if (state_q == RUN) begin
                if (rst_tb_valid && !dma_busy)                  g_rst = 1'b1;
                else if (req_valid && age_prom[0] && !req_stall) g_req = 1'b1;
                else if (dma_valid && age_prom[1] && !req_stall) g_dma = 1'b1;
                else if (rsp_valid)                              g_rsp = 1'b1;
                else if (req_valid && !req_stall)                g_req = 1'b1;
                else if (dma_valid && !req_stall)                g_dma = 1'b1;
            end else if (state_q == RECALL) begin
                g_rsp = rsp_valid;
            end
        end

        case (state_q)
            RUN: begin
                if (load) begin
                    out_valid_d = g_rsp || g_req || g_dma;
                    desc_d      = '0;
                    if (g_rsp)      desc_d.src = SRC_RSP;
                    else if (g_req) desc_d.src = SRC_REQ;
                    else if (g_dma) desc_d.src = SRC_DMA;
                end
                if (g_rst) begin
                    state_d   = SWEEP;
                    flush_d   = rst_tb_flush;
                    cnt_d     = '0;
                    pending_d = recall_open;
                end else if (recall_open) begin
                    state_d = RECALL;
                end
            end
            SWEEP: begin
                if (recall_open)      pending_d = 1'b1;
                else if (recall_done) pending_d = 1'b0;
                // The final beat is consumed without launching a wrapped beat 0.
                if (last_accept) begin
                    out_valid_d  = 1'b0;
                    desc_d       = '0;
                    sweep_done_d = 1'b1;
                    state_d      = pending_d ? RECALL : RUN;
                    pending_d    = 1'b0;
                end else if (load) begin
                    out_valid_d  = 1'b1;
                    desc_d.src   = SRC_RST;
                    desc_d.sweep = 1'b1;
                    desc_d.flush = flush_q;
                    desc_d.set   = LLC_SET_W_MAX'(cnt_q);
                    cnt_d        = cnt_q + SET_BITS'(1);
                end
            end
            RECALL: begin
                if (load) begin
                    out_valid_d = g_rsp;
                    desc_d      = '0;
                    if (g_rsp) desc_d.src = SRC_RSP;
                end
                if (recall_done) state_d = RUN;
                pending_d = 1'b0;
            end
            default: begin
                state_d     = RUN;
                out_valid_d = 1'b0;
                desc_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            desc_q       <= '0;
            out_valid_q  <= 1'b0;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            pending_q    <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            desc_q       <= desc_d;
            out_valid_q  <= out_valid_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            pending_q    <= pending_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // Pops and idle are combinational; holding them low under reset keeps every output quiet.
    assign rst_tb_pop = g_rst && rst;
    assign rsp_pop    = g_rsp && rst;
    assign req_pop    = g_req && rst;
    assign dma_pop    = g_dma && rst;

    assign out_valid  = out_valid_q;
    assign out_src    = desc_q.src;
    assign out_sweep  = desc_q.sweep;
    assign out_flush  = desc_q.flush;
    assign out_set    = desc_q.set[SET_BITS-1:0];
    assign sweep_done = sweep_done_q;
    assign in_recall  = (state_q == RECALL);
    assign idle       = rst && (state_q == RUN) && !out_valid_q &&
                        !(rst_tb_valid || rsp_valid || req_valid || dma_valid);

endmodule

// File: tb/tb_llc_input_scheduler.sv
// Directed bench for llc_input_scheduler: expected pops and descriptors are queued
// by the stimulus and consumed by an independent monitor.
module tb_llc_input_scheduler;

    localparam int SET_BITS = 3;

    localparam logic [3:0] P_RST = 4'b0001;
    localparam logic [3:0] P_RSP = 4'b0010;
    localparam logic [3:0] P_REQ = 4'b0100;
    localparam logic [3:0] P_DMA = 4'b1000;
    localparam logic [1:0] S_RST = 2'd0;
    localparam logic [1:0] S_RSP = 2'd1;
    localparam logic [1:0] S_REQ = 2'd2;
    localparam logic [1:0] S_DMA = 2'd3;

    logic clk = 1'b0;
    logic rst;
    logic rst_tb_valid, rst_tb_flush, rsp_valid, req_valid, dma_valid;
    logic req_stall, dma_busy, recall_start, recall_done, out_ready;
    logic rst_tb_pop, rsp_pop, req_pop, dma_pop, out_valid, out_sweep, out_flush;
    logic sweep_done, in_recall, idle;
    logic [1:0]          out_src;
    logic [SET_BITS-1:0] out_set;

    always #5 clk = ~clk;

    llc_input_scheduler #(
        .SET_BITS     (SET_BITS),
        .STARVE_LIMIT (15),
        .AGE_W        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rst_tb_valid (rst_tb_valid),
        .rst_tb_flush (rst_tb_flush),
        .rsp_valid    (rsp_valid),
        .req_valid    (req_valid),
        .dma_valid    (dma_valid),
        .req_stall    (req_stall),
        .dma_busy     (dma_busy),
        .recall_start (recall_start),
        .recall_done  (recall_done),
        .rst_tb_pop   (rst_tb_pop),
        .rsp_pop      (rsp_pop),
        .req_pop      (req_pop),
        .dma_pop      (dma_pop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_src      (out_src),
        .out_sweep    (out_sweep),
        .out_flush    (out_flush),
        .out_set      (out_set),
        .sweep_done   (sweep_done),
        .in_recall    (in_recall),
        .idle         (idle)
    );

    typedef struct packed {
        logic [1:0]          src;
        logic                sweep;
        logic                flush;
        logic [SET_BITS-1:0] set;
    } exp_desc_t;

    exp_desc_t  exp_desc[$];
    logic [3:0] exp_pop[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] mon_pops, mon_wpop;
    exp_desc_t  mon_got, mon_want;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pop(input logic [3:0] p);
        exp_pop.push_back(p);
    endtask

    task automatic push_desc(input logic [1:0] s, input logic sw, input logic fl,
                             input logic [SET_BITS-1:0] st);
        exp_desc.push_back({s, sw, fl, st});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] outs_vec();
        return {dma_pop, req_pop, rsp_pop, rst_tb_pop, out_valid, out_sweep, out_flush,
                sweep_done, in_recall, idle, out_src, out_set};
    endfunction

    // Monitor: every pop strobe and every accepted descriptor consumes one expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon_pops = {dma_pop, req_pop, rsp_pop, rst_tb_pop};
            if (mon_pops != 4'b0) begin
                if (exp_pop.size() == 0) begin
                    check("sb_pop_unexpected", 32'(mon_pops), 32'd0);
                end else begin
                    mon_wpop = exp_pop.pop_front();
                    check("sb_pop", 32'(mon_pops), 32'(mon_wpop));
                end
            end
            if (out_valid && out_ready) begin
                mon_got = {out_src, out_sweep, out_flush, out_set};
                if (exp_desc.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_desc_unexpected: got %0h expected none (t=%0t)", mon_got, $time);
                end else begin
                    mon_want = exp_desc.pop_front();
                    check("sb_desc", 32'(mon_got), 32'(mon_want));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        rst_tb_valid = 1'b1; rst_tb_flush = 1'b0; rsp_valid = 1'b1; req_valid = 1'b0;
        dma_valid = 1'b0; req_stall = 1'b0; dma_busy = 1'b0; recall_start = 1'b0;
        recall_done = 1'b0; out_ready = 1'b0;

        // Reset: everything low even with sources valid.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(outs_vec()), 32'd0);
        rsp_valid = 1'b0; rst_tb_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("reset_idle", 32'(idle), 32'd1);
        tick();

        // T1: RSP held against REQ; REQ promoted on cycle 16.
        for (int k = 1; k <= 17; k++) begin
            push_pop((k == 16) ? P_REQ : P_RSP);
            push_desc((k == 16) ? S_REQ : S_RSP, 1'b0, 1'b0, '0);
        end
        rsp_valid = 1'b1; req_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 15) check("t1_req_waits", 32'(req_pop), 32'd0);
            if (k == 16) check("t1_req_grant_c16", 32'(req_pop), 32'd1);
            tick();
        end
        rsp_valid = 1'b0; req_valid = 1'b0;
        repeat (3) tick();

        // T2: flush sweep over 8 sets with out_ready held high.
        push_pop(P_RST);
        for (int s = 0; s < 8; s++) push_desc(S_RST, 1'b1, 1'b1, SET_BITS'(s));
        rst_tb_valid = 1'b1; rst_tb_flush = 1'b1;
        for (int j = 0; j <= 11; j++) begin
            if (j == 1) begin rst_tb_valid = 1'b0; rst_tb_flush = 1'b0; end
            @(negedge clk);
            if (j >= 2 && j <= 9) check("t2_beat_valid_flush", 32'({out_valid, out_flush}), 32'd3);
            if (j == 9)  check("t2_last_set", 32'(out_set), 32'd7);
            if (j == 9)  check("t2_done_not_early", 32'(sweep_done), 32'd0);
            if (j == 10) check("t2_sweep_done", 32'(sweep_done), 32'd1);
            if (j == 10) check("t2_no_extra_beat", 32'(out_valid), 32'd0);
            if (j == 11) check("t2_done_pulse", 32'(sweep_done), 32'd0);
            tick();
        end

        // T3: reset sweep with one stall cycle and a recall_start mid-sweep.
        push_pop(P_RST);
        for (int s = 0; s < 8; s++) push_desc(S_RST, 1'b1, 1'b0, SET_BITS'(s));
        for (int j = 0; j <= 12; j++) begin
            if (j == 0) begin rst_tb_valid = 1'b1; rst_tb_flush = 1'b0; out_ready = 1'b1; end
            if (j == 1) rst_tb_valid = 1'b0;
            if (j == 3) begin out_ready = 1'b0; recall_start = 1'b1; end
            if (j == 4) begin out_ready = 1'b1; recall_start = 1'b0; end
            @(negedge clk);
            if (j == 3)  check("t3_set_stalled", 32'(out_set), 32'd1);
            if (j == 4)  check("t3_set_held", 32'({out_valid, out_set}), 32'h9);
            if (j == 10) check("t3_last_set", 32'(out_set), 32'd7);
            if (j == 11) check("t3_sweep_done", 32'(sweep_done), 32'd1);
            if (j == 12) check("t3_recall_after_sweep", 32'({in_recall, sweep_done}), 32'd2);
            tick();
        end

        // T4: RECALL with all channels valid, then rst_tb wins; T6: reset at set 5.
        push_pop(P_RSP); push_pop(P_RSP); push_pop(P_RST);
        push_desc(S_RSP, 1'b0, 1'b0, '0);
        push_desc(S_RSP, 1'b0, 1'b0, '0);
        for (int s = 0; s < 5; s++) push_desc(S_RST, 1'b1, 1'b1, SET_BITS'(s));
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) begin
                rst_tb_valid = 1'b1; rst_tb_flush = 1'b1;
                rsp_valid = 1'b1; req_valid = 1'b1; dma_valid = 1'b1;
            end
            if (k == 1) recall_done = 1'b1;
            if (k == 2) recall_done = 1'b0;
            if (k == 3) begin
                rst_tb_valid = 1'b0; rst_tb_flush = 1'b0;
                rsp_valid = 1'b0; req_valid = 1'b0; dma_valid = 1'b0;
            end
            if (k == 9) out_ready = 1'b0;
            @(negedge clk);
            if (k == 0) check("t4_in_recall", 32'(in_recall), 32'd1);
            if (k <= 1) check("t4_only_rsp", 32'({dma_pop, req_pop, rsp_pop, rst_tb_pop}), 32'(P_RSP));
            if (k == 2) check("t4_rst_tb_wins", 32'({in_recall, dma_pop, req_pop, rsp_pop, rst_tb_pop}), 32'(P_RST));
            if (k == 9) check("t6_at_set5", 32'({out_valid, out_flush, out_set}), 32'h1D);
            if (k < 9) tick();
        end
        #1;
        rst = 1'b0;
        #1;
        check("t6_async_reset", 32'(outs_vec()), 32'd0);
        tick();
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("t6_run_after_reset", 32'({out_valid, in_recall, sweep_done, idle}), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("t6_no_resume", 32'(out_valid), 32'd0);
        end
        tick();

        // T5: dma_busy blocks rst_tb, req_stall blocks DMA; then DMA goes.
        push_pop(P_DMA);
        push_desc(S_DMA, 1'b0, 1'b0, '0);
        dma_busy = 1'b1; rst_tb_valid = 1'b1; dma_valid = 1'b1; req_stall = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            if (k == 2) req_stall = 1'b0;
            if (k == 3) begin dma_valid = 1'b0; rst_tb_valid = 1'b0; dma_busy = 1'b0; end
            @(negedge clk);
            if (k <= 1) check("t5_blocked", 32'({dma_pop, req_pop, rsp_pop, rst_tb_pop, idle}), 32'd0);
            if (k == 2) check("t5_dma_pop", 32'(dma_pop), 32'd1);
            if (k == 4) check("t5_idle_again", 32'(idle), 32'd1);
            tick();
        end

        // T7: recall_start/recall_done collision, then a normal window.
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) begin recall_start = 1'b1; recall_done = 1'b1; end
            if (k == 1) begin recall_start = 1'b0; recall_done = 1'b0; end
            if (k == 2) recall_start = 1'b1;
            if (k == 3) recall_start = 1'b0;
            if (k == 4) recall_done = 1'b1;
            if (k == 5) recall_done = 1'b0;
            @(negedge clk);
            if (k == 1) check("t7_collision_no_window", 32'(in_recall), 32'd0);
            if (k == 3) check("t7_window_open", 32'({in_recall, idle}), 32'd2);
            if (k == 4) check("t7_window_held", 32'(in_recall), 32'd1);
            if (k == 5) check("t7_window_closed", 32'(in_recall), 32'd0);
            tick();
        end

        // T8: RSP held against DMA; DMA promoted on cycle 16.
        for (int k = 1; k <= 16; k++) begin
            push_pop((k == 16) ? P_DMA : P_RSP);
            push_desc((k == 16) ? S_DMA : S_RSP, 1'b0, 1'b0, '0);
        end
        rsp_valid = 1'b1; dma_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) check("t8_dma_waits", 32'(dma_pop), 32'd0);
            if (k == 16) check("t8_dma_grant_c16", 32'(dma_pop), 32'd1);
            tick();
        end
        rsp_valid = 1'b0; dma_valid = 1'b0;
        repeat (3) tick();

        check("sb_pop_drained", 32'(exp_pop.size()), 32'd0);
        check("sb_desc_drained", 32'(exp_desc.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
